fir_coef_sched: RTL and testbench
=================================

// Module: fir_coef_sched
// PURPOSE
//  Run-time coefficient manager and input scheduler in front of the 10-tap FIR (myfir).
//  Holds a shadow and an active coefficient bank. Forwards the sample stream to the FIR.
//  On a commit, it stalls the source, drains every in-flight sample, then swaps banks atomically.
//  Sits between signal_gen and myfir; the FIR's VOUT is fed back for in-flight tracking.
// PARAMETERS
//  NB       10  coefficient/sample width
//  NTAP     10  number of taps (CFG_ADDR valid range 0..NTAP-1)
//  MAX_OUT  15  max in-flight samples (accepted VIN minus observed VOUT); 4-bit counter
//  HOLD_CYC 2   idle cycles after the swap before the source is released
// PORTS
//  CLK        in   1        clock, all logic on rising edge
//  RST        in   1        synchronous, active-high reset
//  CFG_WE     in   1        shadow write strobe
//  CFG_ADDR   in   4        shadow tap index
//  CFG_DATA   in   NB       shadow coefficient value
//  CFG_COMMIT in   1        one-cycle request: shadow -> active
//  CFG_BUSY   out  1        high from an accepted commit until back in RUN
//  CFG_ERR    out  1        one-cycle pulse on any protocol error (see below)
//  S_DIN      in   NB       sample from source
//  S_VIN      in   1        source sample valid
//  S_RDY      out  1        scheduler accepts a sample this cycle
//  F_DIN      out  NB       sample to FIR DIN
//  F_VIN      out  1        valid to FIR VIN
//  F_VOUT     in   1        FIR VOUT (one per consumed sample)
//  B_ALL      out  NTAP*NB  active bank; tap i = B_ALL[i*NB +: NB] -> FIR Bi
// BEHAVIOUR
//  Reset: both banks = 0, F_DIN = 0, F_VIN = 0, CFG_BUSY = 0, CFG_ERR = 0, in-flight cnt = 0, state = RUN.
//  S_RDY is combinational: (state==RUN) & (cnt<MAX_OUT) & ~RST.
//  Accept = S_VIN & S_RDY. F_DIN/F_VIN are registered: F_VIN <= accept; F_DIN <= S_DIN when accept,
//   else F_DIN holds its value. Latency is exactly 1 cycle.
//  cnt update: +1 on accept, -1 on F_VOUT, unchanged when both occur in the same cycle.
//   F_VOUT with cnt==0: cnt stays 0, CFG_ERR pulses.
//  Shadow write: CFG_WE with ADDR<NTAP writes shadow[ADDR] in every state except SWAP.
//   In SWAP, or with ADDR>=NTAP, the write is dropped and CFG_ERR pulses.
//  FSM:
//   RUN   - CFG_COMMIT -> DRAIN; CFG_BUSY=1 the next cycle.
//   DRAIN - S_RDY=0; when cnt==0 and F_VIN==0 -> SWAP.
//   SWAP  - one cycle: active <= shadow (all taps in the same edge); -> HOLD.
//   HOLD  - count HOLD_CYC cycles -> RUN; CFG_BUSY drops on entry to RUN.
//  CFG_COMMIT while CFG_BUSY: ignored, CFG_ERR pulses.
//  A commit in the same cycle as accept: that sample is forwarded and counted. The FIR therefore
//   processes it with the OLD bank.
//  CFG_WE together with CFG_COMMIT in RUN: the write lands before the swap and is included.
//  The active bank changes only in SWAP. It never changes while any sample is in flight.
//  Reset mid-DRAIN/HOLD: immediate return to reset values; the pending commit is lost.
// STRUCTURE
//  Shared package fir_pkg: NB, NTAP, MAX_OUT, state enum {RUN, DRAIN, SWAP, HOLD}.
//  One sub-module: fir_coef_bank (shadow + active register arrays, write port, swap strobe, B_ALL).
//  FSM, in-flight counter and stream register stay in the top level.
// TESTING (bench: clk_gen + signal_gen + myfir + data_sink, with a config driver added)
//  1. Reset, then write taps 0..9 = 1..10 and commit with no traffic -> BUSY for 1+1+2 cycles,
//     then B_ALL tap i = i+1.
//  2. Continuous S_VIN, commit mid-stream -> S_RDY low until cnt==0; no sample is lost or duplicated;
//     data_sink outputs before the swap match the old bank, outputs after match the new bank.
//  3. Source never stalls and FIR VOUT is withheld -> cnt reaches 15, S_RDY=0; one VOUT frees exactly one slot.
//  4. CFG_ADDR=12 write -> CFG_ERR pulse, shadow unchanged. Commit during DRAIN -> CFG_ERR pulse, single swap.
//  5. Accept and F_VOUT in the same cycle, repeated 20 cycles -> cnt constant.
//     F_VOUT with cnt=0 -> CFG_ERR, cnt stays 0.
//  6. RST asserted in DRAIN -> next cycle B_ALL = 0, F_VIN = 0, BUSY = 0, state RUN, S_RDY = 1 after release.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and state type for the FIR coefficient scheduler
package fir_pkg;
    localparam int NB       = 10;
    localparam int NTAP     = 10;
    localparam int MAX_OUT  = 15;
    localparam int HOLD_CYC = 2;
    localparam int CW       = 4;
    localparam int AW       = 4;
    localparam int HW       = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2,
        HOLD  = 2'd3
    } sched_state_t;
endpackage

// File: rtl/fir_coef_sched_if.sv
// rtl/fir_coef_sched_if.sv - config, source stream, FIR stream and active bank signals
interface fir_coef_sched_if;
    import fir_pkg::*;

    logic                 cfg_we;
    logic [AW-1:0]        cfg_addr;
    logic [NB-1:0]        cfg_data;
    logic                 cfg_commit;
    logic                 cfg_busy;
    logic                 cfg_err;
    logic [NB-1:0]        s_din;
    logic                 s_vin;
    logic                 s_rdy;
    logic [NB-1:0]        f_din;
    logic                 f_vin;
    logic                 f_vout;
    logic [NTAP*NB-1:0]   b_all;

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_commit, s_din, s_vin, f_vout,
        input  cfg_busy, cfg_err, s_rdy, f_din, f_vin, b_all
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_commit, s_din, s_vin, f_vout,
        output cfg_busy, cfg_err, s_rdy, f_din, f_vin, b_all
    );
endinterface

// File: rtl/fir_coef_bank.sv
// rtl/fir_coef_bank.sv - shadow and active coefficient banks with atomic swap
module fir_coef_bank
    import fir_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [NB-1:0]      wr_data,
    input  logic               swap,
    output logic [NTAP*NB-1:0] b_all
);
    logic [NB-1:0] shadow [NTAP];
    logic [NB-1:0] active [NTAP];

    // Shadow bank: single write port, address already range-checked by the caller
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAP; i++) shadow[i] <= '0;
        end else begin
            for (int i = 0; i < NTAP; i++) begin
                if (wr_en && (wr_addr == AW'(i))) shadow[i] <= wr_data;
            end
        end
    end

    // Active bank: every tap copied from shadow on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAP; i++) active[i] <= '0;
        end else if (swap) begin
            for (int i = 0; i < NTAP; i++) active[i] <= shadow[i];
        end
    end

    // Flatten the active bank so tap i sits at b_all[i*NB +: NB]
    always_comb begin
        b_all = '0;
        for (int i = 0; i < NTAP; i++) b_all[i*NB +: NB] = active[i];
    end
endmodule

// File: rtl/fir_coef_sched.sv
// rtl/fir_coef_sched.sv - coefficient commit scheduler and sample forwarder in front of the FIR
module fir_coef_sched
    import fir_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    fir_coef_sched_if.slave  bus
);
    sched_state_t  state, state_nx;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold_cnt;
    logic [NB-1:0] f_din_q;
    logic          f_vin_q;
    logic          err_q;
    logic          accept;
    logic          addr_ok;
    logic          wr_ok;
    logic          swap;
    logic          err_nx;

    assign bus.s_rdy    = (state == RUN) && (cnt < CW'(MAX_OUT)) && !rst;
    assign accept       = bus.s_vin && bus.s_rdy;
    assign addr_ok      = bus.cfg_addr < AW'(NTAP);
    assign wr_ok        = bus.cfg_we && addr_ok && (state != SWAP);
    assign err_nx       = (bus.cfg_we && !wr_ok)
                        || (bus.cfg_commit && (state != RUN))
                        || (bus.f_vout && (cnt == '0));
    assign bus.cfg_busy = (state != RUN);
    assign bus.cfg_err  = err_q;
    assign bus.f_din    = f_din_q;
    assign bus.f_vin    = f_vin_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    // Next state: drain waits for both the counter and the output register to be empty
    always_comb begin
        state_nx = state;
        swap     = 1'b0;
        case (state)
            RUN:     if (bus.cfg_commit) state_nx = DRAIN;
            DRAIN:   if ((cnt == '0) && !f_vin_q) state_nx = SWAP;
            SWAP: begin
                swap     = 1'b1;
                state_nx = HOLD;
            end
            HOLD:    if (hold_cnt == HW'(HOLD_CYC - 1)) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // Idle cycles spent in HOLD, restarted whenever HOLD is not active
    always_ff @(posedge clk) begin
        if (rst || (state != HOLD)) hold_cnt <= '0;
        else                        hold_cnt <= hold_cnt + HW'(1);
    end

    // In-flight samples: accepted minus returned, saturating at zero on a spurious return
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept && !bus.f_vout) begin
            cnt <= cnt + CW'(1);
        end else if (!accept && bus.f_vout && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // One-cycle forwarding register towards the FIR
    always_ff @(posedge clk) begin
        if (rst) begin
            f_vin_q <= 1'b0;
            f_din_q <= '0;
        end else begin
            f_vin_q <= accept;
            if (accept) f_din_q <= bus.s_din;
        end
    end

    // Protocol error pulse
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_nx;
    end

    fir_coef_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok),
        .wr_addr (bus.cfg_addr),
        .wr_data (bus.cfg_data),
        .swap    (swap),
        .b_all   (bus.b_all)
    );
endmodule

// File: tb/tb_fir_coef_sched.sv
// tb/tb_fir_coef_sched.sv - self-checking bench for fir_coef_sched
module tb_fir_coef_sched;
    import fir_pkg::*;

    localparam int LAT = 3;

    typedef struct {
        logic [NB-1:0] d;
        bit            newb;
    } smp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_coef_sched_if bus ();
    fir_coef_sched dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_pass  = 0;
    int n_total = 0;

    logic [NTAP*NB-1:0] m_shadow;
    logic [NTAP*NB-1:0] m_active;
    bit                 fir_auto = 1'b0;
    int                 fq[$];

    // Advance one clock; when enabled, emulate the FIR returning VOUT LAT cycles after each VIN
    task automatic tick();
        @(posedge clk);
        #1;
        if (fir_auto) begin
            foreach (fq[k]) fq[k] = fq[k] - 1;
            if (bus.f_vin) fq.push_back(LAT);
            if (fq.size() > 0 && fq[0] <= 0) begin
                bus.f_vout = 1'b1;
                void'(fq.pop_front());
            end else begin
                bus.f_vout = 1'b0;
            end
        end
    endtask

    task automatic cfg_write(input int a, input logic [NB-1:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(a);
        bus.cfg_data = d;
        tick();
        bus.cfg_we   = 1'b0;
        if (a < NTAP) m_shadow[a*NB +: NB] = d;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!bus.cfg_busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_commit = 0;
        bus.s_din = '0; bus.s_vin = 0; bus.f_vout = 0;
        rst = 1'b1;
        tick();
        tick();
        n_total++; if (bus.b_all !== '0) $display("FAIL reset_b_all got %0h exp 0", bus.b_all); else n_pass++;
        n_total++; if (bus.f_vin !== 1'b0) $display("FAIL reset_f_vin got %0b exp 0", bus.f_vin); else n_pass++;
        n_total++; if (bus.f_din !== '0) $display("FAIL reset_f_din got %0h exp 0", bus.f_din); else n_pass++;
        n_total++; if (bus.cfg_busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", bus.cfg_busy); else n_pass++;
        n_total++; if (bus.cfg_err !== 1'b0) $display("FAIL reset_err got %0b exp 0", bus.cfg_err); else n_pass++;
        n_total++; if (bus.s_rdy !== 1'b0) $display("FAIL reset_rdy_in_rst got %0b exp 0", bus.s_rdy); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (bus.s_rdy !== 1'b1) $display("FAIL reset_rdy_release got %0b exp 1", bus.s_rdy); else n_pass++;
        m_shadow = '0;
        m_active = '0;
    endtask

    task automatic test_commit_idle();
        int busy_cycles;
        for (int i = 0; i < NTAP; i++) cfg_write(i, NB'(i + 1));
        n_total++; if (bus.b_all !== m_active) $display("FAIL idle_pre_commit got %0h exp %0h", bus.b_all, m_active); else n_pass++;
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
        busy_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            if (!bus.cfg_busy) break;
            busy_cycles++;
            tick();
        end
        n_total++; if (busy_cycles != 4) $display("FAIL idle_busy_len got %0d exp 4", busy_cycles); else n_pass++;
        m_active = m_shadow;
        for (int i = 0; i < NTAP; i++) begin
            n_total++;
            if (bus.b_all[i*NB +: NB] !== NB'(i + 1))
                $display("FAIL idle_tap%0d got %0d exp %0d", i, bus.b_all[i*NB +: NB], i + 1);
            else n_pass++;
        end
    endtask

    task automatic test_stream();
        smp_t               q[$];
        smp_t               s;
        logic [NTAP*NB-1:0] old_b, new_b, exp_b;
        bit                 committed;
        bit                 ok;
        fq.delete();
        bus.f_vout = 1'b0;
        fir_auto   = 1'b1;
        for (int i = 0; i < NTAP; i++) cfg_write(i, NB'($urandom));
        old_b     = m_active;
        new_b     = m_shadow;
        committed = 1'b0;
        for (int i = 0; i < 80; i++) begin
            bus.s_vin      = ($urandom_range(0, 3) != 0);
            bus.s_din      = NB'($urandom);
            bus.cfg_commit = (i == 12);
            n_total++;
            if (bus.s_rdy !== !bus.cfg_busy)
                $display("FAIL stream_rdy cyc %0d got %0b exp %0b", i, bus.s_rdy, !bus.cfg_busy);
            else n_pass++;
            if (bus.s_vin && bus.s_rdy) q.push_back('{d: bus.s_din, newb: committed});
            tick();
            if (i == 12) committed = 1'b1;
            bus.cfg_commit = 1'b0;
            if (bus.f_vin) begin
                n_total++;
                if (q.size() == 0) begin
                    $display("FAIL stream_extra cyc %0d got sample %0h exp none", i, bus.f_din);
                end else begin
                    n_pass++;
                    s = q.pop_front();
                    exp_b = s.newb ? new_b : old_b;
                    n_total++;
                    if (bus.f_din !== s.d) $display("FAIL stream_data cyc %0d got %0h exp %0h", i, bus.f_din, s.d);
                    else n_pass++;
                    n_total++;
                    if (bus.b_all !== exp_b) $display("FAIL stream_bank cyc %0d got %0h exp %0h", i, bus.b_all, exp_b);
                    else n_pass++;
                end
            end
        end
        bus.s_vin = 1'b0;
        wait_idle(ok);
        n_total++; if (!ok) $display("FAIL stream_idle got busy exp idle"); else n_pass++;
        n_total++; if (q.size() != 0) $display("FAIL stream_lost got %0d pending exp 0", q.size()); else n_pass++;
        for (int k = 0; k < LAT + 3; k++) tick();
        fir_auto   = 1'b0;
        bus.f_vout = 1'b0;
        n_total++; if (fq.size() != 0) $display("FAIL stream_fir_drain got %0d exp 0", fq.size()); else n_pass++;
        m_active = m_shadow;
        n_total++; if (bus.b_all !== m_active) $display("FAIL stream_final_bank got %0h exp %0h", bus.b_all, m_active); else n_pass++;
    endtask

    task automatic test_stall();
        int acc;
        bus.s_vin = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            bus.s_din = NB'($urandom);
            if (bus.s_rdy) acc++;
            tick();
        end
        bus.s_vin = 1'b0;
        n_total++; if (acc != MAX_OUT) $display("FAIL stall_accepts got %0d exp %0d", acc, MAX_OUT); else n_pass++;
        n_total++; if (bus.s_rdy !== 1'b0) $display("FAIL stall_rdy_full got %0b exp 0", bus.s_rdy); else n_pass++;
        bus.f_vout = 1'b1;
        tick();
        bus.f_vout = 1'b0;
        n_total++; if (bus.s_rdy !== 1'b1) $display("FAIL stall_one_slot got %0b exp 1", bus.s_rdy); else n_pass++;
        bus.s_vin = 1'b1;
        tick();
        bus.s_vin = 1'b0;
        n_total++; if (bus.s_rdy !== 1'b0) $display("FAIL stall_refull got %0b exp 0", bus.s_rdy); else n_pass++;
        bus.f_vout = 1'b1;
        repeat (MAX_OUT) tick();
        bus.f_vout = 1'b0;
        n_total++; if (bus.cfg_err !== 1'b0) $display("FAIL stall_drain_err got %0b exp 0", bus.cfg_err); else n_pass++;
        n_total++; if (bus.s_rdy !== 1'b1) $display("FAIL stall_drained_rdy got %0b exp 1", bus.s_rdy); else n_pass++;
    endtask

    task automatic test_err_cases();
        bit ok;
        int busy_seen;
        cfg_write(12, NB'($urandom));
        n_total++; if (bus.cfg_err !== 1'b1) $display("FAIL err_bad_addr got %0b exp 1", bus.cfg_err); else n_pass++;
        tick();
        n_total++; if (bus.cfg_err !== 1'b0) $display("FAIL err_pulse_len got %0b exp 0", bus.cfg_err); else n_pass++;
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
        wait_idle(ok);
        n_total++; if (!ok || bus.b_all !== m_shadow) $display("FAIL err_shadow_kept got %0h exp %0h", bus.b_all, m_shadow); else n_pass++;
        bus.s_vin = 1'b1;
        repeat (3) tick();
        bus.s_vin = 1'b0;
        cfg_write(3, NB'($urandom));
        bus.cfg_commit = 1'b1;
        tick();
        tick();
        bus.cfg_commit = 1'b0;
        n_total++; if (bus.cfg_err !== 1'b1) $display("FAIL err_commit_in_drain got %0b exp 1", bus.cfg_err); else n_pass++;
        cfg_write(5, NB'($urandom));
        n_total++; if (bus.cfg_err !== 1'b0) $display("FAIL err_write_in_drain got %0b exp 0", bus.cfg_err); else n_pass++;
        n_total++; if (bus.b_all !== m_active) $display("FAIL err_bank_held got %0h exp %0h", bus.b_all, m_active); else n_pass++;
        bus.f_vout = 1'b1;
        repeat (3) tick();
        bus.f_vout = 1'b0;
        wait_idle(ok);
        m_active = m_shadow;
        n_total++; if (!ok || bus.b_all !== m_active) $display("FAIL err_drain_swap got %0h exp %0h", bus.b_all, m_active); else n_pass++;
        busy_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.cfg_busy) busy_seen++;
        end
        n_total++; if (busy_seen != 0) $display("FAIL err_single_swap got %0d busy cycles exp 0", busy_seen); else n_pass++;
    endtask

    task automatic test_same_cycle();
        int rdy_low, errs, acc;
        bus.s_vin = 1'b1;
        tick();
        bus.f_vout = 1'b1;
        rdy_low = 0;
        errs    = 0;
        for (int i = 0; i < 20; i++) begin
            bus.s_din = NB'($urandom);
            if (!bus.s_rdy) rdy_low++;
            tick();
            if (bus.cfg_err) errs++;
        end
        bus.f_vout = 1'b0;
        n_total++; if (rdy_low != 0) $display("FAIL same_rdy got %0d low cycles exp 0", rdy_low); else n_pass++;
        n_total++; if (errs != 0) $display("FAIL same_err got %0d exp 0", errs); else n_pass++;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.s_rdy) acc++;
            tick();
        end
        bus.s_vin = 1'b0;
        n_total++; if (acc != MAX_OUT - 1) $display("FAIL same_cnt_const got %0d exp %0d", acc, MAX_OUT - 1); else n_pass++;
        bus.f_vout = 1'b1;
        repeat (MAX_OUT) tick();
        tick();
        bus.f_vout = 1'b0;
        n_total++; if (bus.cfg_err !== 1'b1) $display("FAIL same_vout_at_zero got %0b exp 1", bus.cfg_err); else n_pass++;
        tick();
        n_total++; if (bus.cfg_err !== 1'b0) $display("FAIL same_err_pulse got %0b exp 0", bus.cfg_err); else n_pass++;
        bus.s_vin = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.s_rdy) acc++;
            tick();
        end
        bus.s_vin = 1'b0;
        n_total++; if (acc != MAX_OUT) $display("FAIL same_cnt_stays_zero got %0d exp %0d", acc, MAX_OUT); else n_pass++;
        bus.f_vout = 1'b1;
        repeat (MAX_OUT) tick();
        bus.f_vout = 1'b0;
    endtask

    task automatic test_reset_in_drain();
        bit ok;
        bus.s_vin = 1'b1;
        repeat (2) tick();
        bus.s_vin = 1'b0;
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
        tick();
        n_total++; if (bus.cfg_busy !== 1'b1) $display("FAIL rst_drain_busy got %0b exp 1", bus.cfg_busy); else n_pass++;
        rst = 1'b1;
        tick();
        n_total++; if (bus.b_all !== '0) $display("FAIL rst_drain_bank got %0h exp 0", bus.b_all); else n_pass++;
        n_total++; if (bus.f_vin !== 1'b0) $display("FAIL rst_drain_f_vin got %0b exp 0", bus.f_vin); else n_pass++;
        n_total++; if (bus.cfg_busy !== 1'b0) $display("FAIL rst_drain_busy_clr got %0b exp 0", bus.cfg_busy); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (bus.s_rdy !== 1'b1) $display("FAIL rst_drain_rdy got %0b exp 1", bus.s_rdy); else n_pass++;
        m_shadow = '0;
        m_active = '0;
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
        wait_idle(ok);
        n_total++; if (!ok || bus.b_all !== m_shadow) $display("FAIL rst_drain_shadow_clr got %0h exp %0h", bus.b_all, m_shadow); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_commit_idle();
        test_stream();
        test_stall();
        test_err_cases();
        test_same_cycle();
        test_reset_in_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule
